// File: rtl/bitwise_logic_pkg.sv
// Shared constants for the bitwise logic unit:
// op codes and FSM state encodings.
package bitwise_logic_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational bitwise op: y = op(x, z).
// Ports: op (3b code), x/z operands, y result.
module bitwise_op_core
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == OP_AND):  y = x & z;
      (op == OP_NAND): y = ~(x & z);
      (op == OP_OR):   y = x | z;
      (op == OP_NOR):  y = ~(x | z);
      (op == OP_XOR):  y = x ^ z;
      (op == OP_XNOR): y = ~(x ^ z);
      (op == OP_NOT):  y = ~x;
      (op == OP_PASS): y = x;
      default:         y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit_p.sv
// Registered bitwise logic unit with optional multi-beat reduce frames.
// Ports: clk, rst_n, in_* (valid/ready beat), out_* (valid/ready result).
module bitwise_logic_unit_p
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNTW-1:0]  out_cnt,
  output logic             out_ovf
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [0:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNTW-1:0]  cnt;
  logic [2:0]       op_q;
  logic             ovf_q;

  logic [WIDTH-1:0] y_ab;
  logic [WIDTH-1:0] y_acc;
  logic [CNTW-1:0]  cnt_inc;
  logic             cnt_sat;
  logic             ovf_nxt;
  logic             fire;

  assign in_ready = !out_valid | out_ready;
  assign fire     = in_valid & in_ready;

  // A beat that finds the counter full was not counted: flag it.
  assign cnt_sat = (cnt == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt : cnt + CNT_ONE;
  assign ovf_nxt = ovf_q | cnt_sat;

  bitwise_op_core #(.WIDTH(WIDTH)) u_ab (
    .op (in_op),
    .x  (in_a),
    .z  (in_b),
    .y  (y_ab)
  );

  bitwise_op_core #(.WIDTH(WIDTH)) u_acc (
    .op (op_q),
    .x  (acc),
    .z  (in_a),
    .y  (y_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= OP_AND;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      // A load below overrides this clear.
      if (out_valid & out_ready)
        out_valid <= 1'b0;
      if (fire) begin
        unique case (1'b1)
          (state == ST_IDLE): begin
            if (!in_acc) begin
              out_y     <= y_ab;
              out_cnt   <= CNT_ONE;
              out_ovf   <= 1'b0;
              out_valid <= 1'b1;
            end else if (in_last) begin
              out_y     <= in_a;
              out_cnt   <= CNT_ONE;
              out_ovf   <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc   <= in_a;
              op_q  <= in_op;
              cnt   <= CNT_ONE;
              ovf_q <= 1'b0;
              state <= ST_ACCUM;
            end
          end
          (state == ST_ACCUM): begin
            acc   <= y_acc;
            cnt   <= cnt_inc;
            ovf_q <= ovf_nxt;
            if (in_last) begin
              out_y     <= y_acc;
              out_cnt   <= cnt_inc;
              out_ovf   <= ovf_nxt;
              out_valid <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
